// File: rtl/dmem_q15_fp16_streamer_pkg.sv
// ============================================================================
// dmem_q15_fp16_streamer_pkg : shared fp16 constants, FSM states, MSB helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package dmem_q15_fp16_streamer_pkg;

    localparam int FP16_BIAS  = 15;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_EXP_W = 5;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [3:0] msb_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_q15_fp16_streamer_q15_to_fp16.sv
// ============================================================================
// q15_to_fp16 : combinational Q1.15 to IEEE-754 binary16, round-nearest-even
// Revision: 1.0
// ============================================================================
`default_nettype none

module q15_to_fp16 (
    input  logic [15:0] q,
    output logic [15:0] f
);
    import dmem_q15_fp16_streamer_pkg::*;

    logic                  sign;
    logic [15:0]           mag;
    logic [3:0]            p;
    logic [14:0]           norm;
    logic                  round_up;
    logic [FP16_MAN_W:0]   man_rnd;
    logic [FP16_EXP_W-1:0] exp_field;

    always_comb begin
        sign     = q[15];
        mag      = sign ? (~q + 16'd1) : q;
        p        = msb_index(mag);
        // Left-justify so the implicit one sits just above norm[14].
        norm     = 15'(mag << (4'd15 - p));
        round_up = norm[4] & ((|norm[3:0]) | norm[5]);
        man_rnd  = {1'b0, norm[14:5]} + {{FP16_MAN_W{1'b0}}, round_up};
        // Biased exponent equals p because the bias cancels the 2^-15 scale.
        exp_field = {1'b0, p} + {{(FP16_EXP_W-1){1'b0}}, man_rnd[FP16_MAN_W]};
        f = FP16_ZERO;
        if (mag == 16'd0) begin
            f = FP16_ZERO;
        end else if (p == 4'd0) begin
            f = {sign, 15'h0200};
        end else begin
            f = {sign, exp_field, man_rnd[FP16_MAN_W-1:0]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_q15_fp16_streamer.sv
// ============================================================================
// dmem_q15_fp16_streamer : walks a ROM window and streams words as fp16
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_q15_fp16_streamer #(
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              out_last
);
    import dmem_q15_fp16_streamer_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              s1_valid_q, s1_valid_d;
    logic [15:0]       s1_data_q, s1_data_d;
    logic              s1_last_q, s1_last_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_data_q, out_data_d;
    logic              out_last_q, out_last_d;

    logic              adv;
    logic              issue;
    logic [15:0]       conv_data;

    q15_to_fp16 u_conv (
        .q (s1_data_q),
        .f (conv_data)
    );

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_last_d   = s1_last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        issue       = 1'b0;
        adv         = out_ready | ~out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        rom_addr_d  = base;
                        remaining_d = len;
                        busy_d      = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (adv) begin
                    issue       = 1'b1;
                    rom_addr_d  = rom_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    remaining_d = remaining_q - {{(LEN_W-1){1'b0}}, 1'b1};
                    if (remaining_q == {{(LEN_W-1){1'b0}}, 1'b1}) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid_q & out_ready & out_last_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Whole pipeline moves in lock-step so stalls never drop or repeat a word.
        if (adv) begin
            s1_valid_d  = issue;
            s1_data_d   = rom_q;
            s1_last_d   = issue & (remaining_q == {{(LEN_W-1){1'b0}}, 1'b1});
            out_valid_d = s1_valid_q;
            out_last_d  = s1_last_q;
            if (s1_valid_q) out_data_d = conv_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= 16'h0000;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= FP16_ZERO;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rom_addr  = rom_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

`default_nettype wire
